// File: rtl/core_pkg.sv
// Shared core definitions for the fetch stage.
//   XLEN          : PC and instruction width
//   RESET_PC      : default word address fetched first after reset
//   fetch_entry_t : one buffered instruction together with its PC
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous circular FIFO of fetch_entry_t.
//   clk, nrst : clock, asynchronous active-low reset
//   flush     : empty the buffer (wins over push and pop)
//   push      : write push_data at the tail
//   pop       : retire the head entry
//   head      : current head entry (meaningful when count != 0)
//   count     : occupancy, 0..DEPTH
// The producer never pushes when full and never pops when empty.
module fetch_buffer
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  head_q;
  logic [PW-1:0]  tail_q;
  logic [CW-1:0]  count_q;

  // Wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= next_ptr(tail_q);
      if (pop)  head_q <= next_ptr(head_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail_q] <= push_data;
  end

  assign head  = mem[head_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the word-addressed fetch PC, issues one
// instruction-memory read per cycle under a credit limit, buffers the
// responses and hands them to decode over valid/ready.
//   clk, nrst          : clock, asynchronous active-low reset
//   redirect, target   : reload the PC and discard all wrong-path work
//   imem_req/imem_addr : read request and word address
//   imem_rdata         : read data, one cycle after the request
//   if_valid/if_instr/if_pc : head instruction toward decode
//   id_ready           : decode accepts the head this cycle
module fetch_unit #(
  parameter int unsigned XLEN = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);

  import core_pkg::*;

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            inflight_q;
  logic            kill_q;
  logic [CW-1:0]   count;
  logic [CW1-1:0]  pending;
  logic            pop;
  logic            push;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  assign if_valid = (count != '0) && !redirect;
  assign pop      = if_valid && id_ready;

  // Credit: entries held plus the one in flight, less the one leaving now,
  // must leave room for the response this request will produce.
  assign pending  = {1'b0, count} + CW1'(inflight_q) - CW1'(pop);
  assign imem_req = nrst && !redirect && (pending < CW1'(DEPTH));
  assign imem_addr = pc_q;

  // A response landing in a redirect cycle is wrong-path and dropped.
  assign push      = inflight_q && !kill_q && !redirect;
  assign push_data = '{instr: imem_rdata, pc: req_pc_q};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      inflight_q <= imem_req;
      kill_q     <= redirect && inflight_q;
      if (redirect) begin
        pc_q <= target;
      end else if (imem_req) begin
        pc_q     <= pc_q + 1'b1;
        req_pc_q <= pc_q;
      end
    end
  end

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk       (clk),
    .nrst      (nrst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, with
// a program-order scoreboard and an occupancy-credit model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFE;
  localparam logic [31:0] TAG     = 32'hA000_0000;
  localparam int          DEPTH   = 2;

  logic        clk;
  logic        nrst;
  logic        redirect;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  // Second instance: wraps through the top of the address space.
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_ready;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] exp_pc;     // next PC decode should receive
  logic [31:0] next_addr;  // next address fetch should request
  int          occ;        // requests issued since the last flush, minus pops
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] w_exp;
  logic        w_m_req;
  logic [31:0] w_m_addr;
  int          w_deliv;
  logic        p_valid;
  logic        p_pop;
  logic [31:0] p_pc;
  logic [31:0] p_instr;

  // Sampled outputs of the latest step
  logic        s_valid;
  logic        s_req;
  logic [31:0] s_pc;
  int          reqs;

  fetch_unit u_dut (
    .clk        (clk),
    .nrst       (nrst),
    .redirect   (redirect),
    .target     (target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready)
  );

  fetch_unit #(
    .RESET_PC(WRAP_PC)
  ) u_wrap (
    .clk        (clk),
    .nrst       (nrst),
    .redirect   (w_redirect),
    .target     (w_target),
    .imem_req   (w_req),
    .imem_addr  (w_addr),
    .imem_rdata (w_rdata),
    .if_valid   (w_valid),
    .if_instr   (w_instr),
    .if_pc      (w_pc),
    .id_ready   (w_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc    = RST_PC;
    next_addr = RST_PC;
    occ       = 0;
    m_req     = 1'b0;
    m_addr    = '0;
    w_exp     = WRAP_PC;
    w_m_req   = 1'b0;
    w_m_addr  = '0;
    w_deliv   = 0;
    p_valid   = 1'b0;
    p_pop     = 1'b0;
    p_pc      = '0;
    p_instr   = '0;
  endtask

  // One clock cycle: drive inputs, let them settle, check, advance.
  task automatic step(input logic rd, input logic [31:0] tg, input logic rdy);
    logic pop;
    logic exp_req;
    redirect   = rd;
    target     = tg;
    id_ready   = rdy;
    imem_rdata = m_req ? TAG + m_addr : $urandom;
    w_rdata    = w_m_req ? TAG + w_m_addr : $urandom;
    #2;
    s_valid = if_valid;
    s_req   = imem_req;
    s_pc    = if_pc;
    pop     = if_valid & rdy;

    if (rd) chk("redirect_valid_low", 32'(if_valid), 32'd0);
    if (p_valid && !p_pop && !rd) begin
      chk("no_bubble", 32'(if_valid), 32'd1);
      chk("hold_pc", if_pc, p_pc);
      chk("hold_instr", if_instr, p_instr);
    end
    if (if_valid) chk("instr_data", if_instr, TAG + if_pc);
    if (pop) begin
      chk("pc_order", if_pc, exp_pc);
      exp_pc = exp_pc + 32'd1;
    end

    exp_req = !rd && ((occ - int'(pop)) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, next_addr);

    if (rd) begin
      exp_pc    = tg;
      next_addr = tg;
      occ       = 0;
    end else begin
      occ = occ + int'(exp_req) - int'(pop);
      if (exp_req) next_addr = next_addr + 32'd1;
    end
    if (occ > DEPTH) chk("credit_limit", 32'(occ), 32'(DEPTH));

    if (w_valid) begin
      chk("wrap_instr", w_instr, TAG + w_pc);
      chk("wrap_pc_order", w_pc, w_exp);
      w_exp = w_exp + 32'd1;
      w_deliv++;
    end

    m_req    = imem_req;
    m_addr   = imem_addr;
    w_m_req  = w_req;
    w_m_addr = w_addr;
    p_valid  = if_valid;
    p_pop    = pop;
    p_pc     = if_pc;
    p_instr  = if_instr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        rd;
    logic [31:0] tg;
    logic        rdy;

    nrst       = 1'b0;
    redirect   = 1'b0;
    target     = '0;
    id_ready   = 1'b0;
    imem_rdata = '0;
    w_rdata    = '0;
    w_redirect = 1'b0;
    w_target   = '0;
    w_ready    = 1'b1;
    model_reset();

    // Reset values
    #12;
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_valid", 32'(if_valid), 32'd0);
    chk("reset_addr", imem_addr, RST_PC);
    chk("wrap_reset_addr", w_addr, WRAP_PC);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Streaming with decode always ready
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, 1'b1);
      if (i < 2) chk("first_valid_early", 32'(s_valid), 32'd0);
      if (i == 2) begin
        chk("first_valid", 32'(s_valid), 32'd1);
        chk("first_pc", s_pc, RST_PC);
      end
      if (i >= 2) chk("stream_valid", 32'(s_valid), 32'd1);
    end
    chk("wrap_delivered", 32'(w_deliv >= 3), 32'd1);

    // Asynchronous reset mid-stream
    #3;
    nrst = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_valid", 32'(if_valid), 32'd0);
    chk("async_rst_wrap_valid", 32'(w_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("async_rst_addr", imem_addr, RST_PC);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Backpressure from the first cycle after reset
    reqs = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, '0, 1'b0);
      reqs += int'(s_req);
      if (i >= 2) begin
        chk("stall_valid", 32'(s_valid), 32'd1);
        chk("stall_pc", s_pc, RST_PC);
      end
    end
    chk("stall_reqs", 32'(reqs), 32'd2);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Redirect with one entry buffered and one in flight
    step(1'b1, 32'h100, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("redir_bubble1", 32'(s_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("redir_bubble2", 32'(s_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("redir_first_valid", 32'(s_valid), 32'd1);
    chk("redir_first_pc", s_pc, 32'h100);
    step(1'b0, '0, 1'b1);
    chk("redir_second_pc", s_pc, 32'h101);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Back-to-back redirects: the last one wins
    step(1'b1, 32'h40, 1'b1);
    step(1'b1, 32'h80, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("b2b_valid", 32'(s_valid), 32'd1);
    chk("b2b_pc", s_pc, 32'h80);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rd  = ($urandom_range(0, 9) == 0);
      tg  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                        : $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      step(rd, tg, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
